// File: rtl/mips_cpu_muldiv.sv
// HI/LO multiply-divide unit: iterative shift-add multiplier and restoring divider.
// Define MIPS_CPU_MULDIV_FAST_MUL_EN to compute MULT/MULTU in a single cycle.
module mips_cpu_muldiv #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned FUNC_W = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [FUNC_W-1:0] func,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [WIDTH-1:0]  rdata,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [FUNC_W-1:0] F_MULT  = FUNC_W'('b011000);
   localparam logic [FUNC_W-1:0] F_MULTU = FUNC_W'('b011001);
   localparam logic [FUNC_W-1:0] F_DIV   = FUNC_W'('b011010);
   localparam logic [FUNC_W-1:0] F_DIVU  = FUNC_W'('b011011);
   localparam logic [FUNC_W-1:0] F_MTHI  = FUNC_W'('b010001);
   localparam logic [FUNC_W-1:0] F_MTLO  = FUNC_W'('b010011);
   localparam logic [FUNC_W-1:0] F_MFHI  = FUNC_W'('b010000);
   localparam logic [FUNC_W-1:0] F_MFLO  = FUNC_W'('b010010);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]  acc_q, acc_d, mq_q, mq_d, opd_q, opd_d, araw_q, araw_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              done_q, done_d, neg_q, neg_d, rneg_q, rneg_d;
   logic              div0_q, div0_d, isdiv_q, isdiv_d;

   logic              valid, accept, sgn, is_mul;
   logic [WIDTH-1:0]  mag_a, mag_b;
   logic [WIDTH:0]    sh, sum;
   logic [2*WIDTH-1:0] prod;

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   always_comb begin
      valid  = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU) ||
               (func == F_MTHI) || (func == F_MTLO) || (func == F_MFHI) || (func == F_MFLO);
      accept = start & valid & (state_q == S_IDLE);
      stall  = start & busy & valid;
      rdata  = '0;
      if (accept && func == F_MFHI) rdata = hi_q;
      if (accept && func == F_MFLO) rdata = lo_q;
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      opd_d   = opd_q;
      araw_d  = araw_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      div0_d  = div0_q;
      isdiv_d = isdiv_q;
      done_d  = 1'b0;
      sgn     = (func == F_MULT) || (func == F_DIV);
      is_mul  = (func == F_MULT) || (func == F_MULTU);
      mag_a   = (sgn && a[WIDTH-1]) ? -a : a;
      mag_b   = (sgn && b[WIDTH-1]) ? -b : b;
      sh      = {acc_q, mq_q[WIDTH-1]};
      sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opd_q} : '0);
      prod    = {acc_q, mq_q};

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (func == F_MTHI) hi_d = a;
               if (func == F_MTLO) lo_d = a;
               if (is_mul || func == F_DIV || func == F_DIVU) begin
                  neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                  rneg_d  = sgn & a[WIDTH-1];
                  araw_d  = a;
                  div0_d  = (b == '0);
                  isdiv_d = ~is_mul;
                  cnt_d   = '0;
                  acc_d   = '0;
                  // Multiplier: mq holds |b| and shifts out LSB-first; divider: mq holds |a| MSB-first.
                  mq_d    = is_mul ? mag_b : mag_a;
                  opd_d   = is_mul ? mag_a : mag_b;
                  state_d = is_mul ? S_MUL : S_DIV;
               end
            end
         end
         S_MUL: begin
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
            prod = {{WIDTH{1'b0}}, opd_q} * {{WIDTH{1'b0}}, mq_q};
            if (neg_q) prod = -prod;
            {hi_d, lo_d} = prod;
            done_d  = 1'b1;
            state_d = S_IDLE;
`else
            {acc_d, mq_d} = {sum, mq_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIXUP;
`endif
         end
         S_DIV: begin
            if (sh >= {1'b0, opd_q}) begin
               acc_d = WIDTH'(sh - {1'b0, opd_q});
               mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = sh[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIXUP;
         end
         default: begin
            if (isdiv_q) begin
               lo_d = div0_q ? '1 : (neg_q ? -mq_q : mq_q);
               hi_d = div0_q ? araw_q : (rneg_q ? -acc_q : acc_q);
            end else begin
               if (neg_q) prod = -prod;
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         opd_q   <= '0;
         araw_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
         isdiv_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         opd_q   <= opd_d;
         araw_q  <= araw_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div0_q  <= div0_d;
         isdiv_q <= isdiv_d;
      end
   end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv (WIDTH=32).
module tb_mips_cpu_muldiv;

   localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                          F_DIVU = 6'b011011, F_MTHI = 6'b010001, F_MTLO = 6'b010011,
                          F_MFHI = 6'b010000, F_MFLO = 6'b010010;
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  func = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, stall, done;
   logic [31:0] rdata, hi, lo;

   int checks = 0;
   int failures = 0;
   int cyc;
   logic stall_ok, done_seen;

   mips_cpu_muldiv #(.WIDTH(32), .FUNC_W(6)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .func(func), .a(a), .b(b),
      .busy(busy), .stall(stall), .done(done), .rdata(rdata), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the first negedge after the accepting edge.
   task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
      start = 1'b1; func = f; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
   endtask

   task automatic wait_idle(output int n, output logic dseen);
      n = 0; dseen = 1'b0;
      while (busy && n < 200) begin
         if (done) dseen = 1'b1;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      logic ds;
      issue(f, av, bv);
      wait_idle(n, ds);
      check({tag, "_latency"}, 32'(n), 32'(lat));
      check({tag, "_early_done"}, {31'b0, ds}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      @(negedge clk);
      check({tag, "_done_clear"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; func = F_MFLO; #1;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_stall", {31'b0, stall}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      start = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);

      run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'h00000007, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("mult_int_min", F_MULT, 32'h80000000, 32'h80000000, MUL_LAT, 32'h40000000, 32'h00000000);
      run_op("div_m7_2",  F_DIV,   32'hFFFFFFF9, 32'h00000002, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h00000000, 32'h80000000);
      run_op("divu_zero", F_DIVU,  32'h12345678, 32'h00000000, DIV_LAT, 32'h12345678, 32'hFFFFFFFF);
      run_op("div_zero",  F_DIV,   32'hFFFFFFF9, 32'h00000000, DIV_LAT, 32'hFFFFFFF9, 32'hFFFFFFFF);
      run_op("divu_100_7", F_DIVU, 32'd100,      32'd7,        DIV_LAT, 32'd2,        32'd14);
      run_op("div_7_m2",  F_DIV,   32'd7,        32'hFFFFFFFE, DIV_LAT, 32'd1,        32'hFFFFFFFD);

      // MTLO then MFHI
      issue(F_MTLO, 32'h0000ABCD, 32'd0);
      check("mtlo_lo", lo, 32'h0000ABCD);
      check("mtlo_busy", {31'b0, busy}, 32'd0);
      check("mtlo_done", {31'b0, done}, 32'd0);
      start = 1'b1; func = F_MFHI; #1;
      check("mfhi_rdata", rdata, 32'd1);
      @(negedge clk);
      issue(F_MTHI, 32'hCAFEF00D, 32'd0);
      check("mthi_hi", hi, 32'hCAFEF00D);
      check("mthi_lo_kept", lo, 32'h0000ABCD);

      // MFLO held while MULT busy: stalls, then returns new lo in done cycle
      issue(F_MULT, 32'd5, 32'd6);
      start = 1'b1; func = F_MFLO;
      cyc = 0; stall_ok = 1'b1;
      while (busy && cyc < 200) begin
         #1;
         if (stall !== 1'b1 || rdata !== 32'd0) stall_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      #1;
      check("mflo_stall_cycles", 32'(cyc), 32'(MUL_LAT));
      check("mflo_stall_each", {31'b0, stall_ok}, 32'd1);
      check("mflo_done", {31'b0, done}, 32'd1);
      check("mflo_stall_off", {31'b0, stall}, 32'd0);
      check("mflo_rdata_new", rdata, 32'h0000001E);
      @(negedge clk);
      start = 1'b0;
      check("mflo_no_busy", {31'b0, busy}, 32'd0);

      // Unlisted funct
      start = 1'b1; func = 6'b100001; a = 32'h55555555; #1;
      check("bad_stall", {31'b0, stall}, 32'd0);
      check("bad_rdata", rdata, 32'd0);
      @(negedge clk);
      check("bad_busy", {31'b0, busy}, 32'd0);
      check("bad_hi", hi, 32'd0);
      check("bad_lo", lo, 32'h0000001E);
      start = 1'b0;

      // Reset in 10th busy cycle of DIV
      issue(F_DIV, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      check("rst_busy_before", {31'b0, busy}, 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      reset_n = 1'b1;
      done_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      check("rst_no_done", {31'b0, done_seen}, 32'd0);
      check("rst_lo_stays", lo, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
